// File: rtl/data_ram_mmio.sv
// rtl/data_ram_mmio.sv - data-memory responder: big-endian lane RAM plus timer/GPIO register block
module data_ram_mmio #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int          GPIO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              timer_int_o,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              bad_addr_o
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] OFF_COUNT   = 2'd0;
    localparam logic [1:0] OFF_COMPARE = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_GPIO    = 2'd3;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       count_q;
    logic [31:0]       compare_q;
    logic              pending_q;
    logic [GPIO_W-1:0] gpio_q;
    logic              bad_q;

    logic              ram_hit;
    logic              mmio_hit;
    logic              unmapped;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        reg_off;
    logic              rd_en;
    logic              ram_wr;
    logic              mmio_wr;
    logic              timer_match;
    logic              status_clr;
    logic [31:0]       gpio_word;
    logic [31:0]       reg_rdata;
    logic              unused_addr_bits;

    // sel_i[n] governs bits 8n+7:8n; lane 3 is the lowest byte address
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign ram_hit          = (addr_i[31:ADDR_W+2] == '0);
    assign mmio_hit         = !ram_hit && (addr_i[31:4] == MMIO_BASE[31:4]);
    assign unmapped         = !ram_hit && !mmio_hit;
    assign word_idx         = addr_i[ADDR_W+1:2];
    assign reg_off          = addr_i[3:2];
    assign unused_addr_bits = ^addr_i[1:0];

    assign rd_en   = ce_i && !we_i;
    assign ram_wr  = rst && ce_i && we_i && ram_hit;
    assign mmio_wr = ce_i && we_i && mmio_hit;

    assign gpio_word   = 32'(gpio_q);
    assign timer_match = (compare_q != '0) && (count_q == compare_q);
    assign status_clr  = mmio_wr && (reg_off == OFF_STATUS) && sel_i[0] && data_i[0];

    always_comb begin
        reg_rdata = '0;
        case (reg_off)
            OFF_COUNT:   reg_rdata = count_q;
            OFF_COMPARE: reg_rdata = compare_q;
            OFF_STATUS:  reg_rdata = {31'd0, pending_q};
            OFF_GPIO:    reg_rdata = gpio_word;
            default:     reg_rdata = '0;
        endcase
    end

    always_comb begin
        data_o = '0;
        if (rd_en) begin
            if (ram_hit) begin
                data_o = mem[word_idx];
            end else if (mmio_hit) begin
                data_o = reg_rdata;
            end
        end
    end

    // RAM is not reset; writes presented while rst is low are dropped
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q   <= '0;
            compare_q <= '0;
            pending_q <= 1'b0;
            gpio_q    <= '0;
            bad_q     <= 1'b0;
        end else begin
            if (mmio_wr && reg_off == OFF_COUNT) begin
                count_q <= lane_merge(count_q, data_i, sel_i);
            end else begin
                count_q <= count_q + 32'd1;
            end

            if (mmio_wr && reg_off == OFF_COMPARE) begin
                compare_q <= lane_merge(compare_q, data_i, sel_i);
            end

            // a match on the same edge as a clear keeps the interrupt pending
            if (timer_match) begin
                pending_q <= 1'b1;
            end else if (status_clr) begin
                pending_q <= 1'b0;
            end

            if (mmio_wr && reg_off == OFF_GPIO) begin
                gpio_q <= GPIO_W'(lane_merge(gpio_word, data_i, sel_i));
            end

            bad_q <= ce_i && unmapped;
        end
    end

    assign timer_int_o = pending_q;
    assign gpio_o      = gpio_q;
    assign bad_addr_o  = bad_q;

endmodule

// File: tb/tb_data_ram_mmio.sv
// tb/tb_data_ram_mmio.sv - self-checking bench for data_ram_mmio
module tb_data_ram_mmio;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        timer_int_o;
    logic [15:0] gpio_o;
    logic        bad_addr_o;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_bad;
    } vec_t;

    vec_t tbl [$];

    data_ram_mmio #(.ADDR_W(10), .MMIO_BASE(MB), .GPIO_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .timer_int_o (timer_int_o),
        .gpio_o      (gpio_o),
        .bad_addr_o  (bad_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at posedge+1; drives one access, checks data_o at negedge, returns at next posedge+1
    task automatic access(input logic ce, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] data,
                          input logic [31:0] exp, input string name);
        ce_i = ce; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
        exp_q.push_back(exp);
        @(negedge clk);
        check32(name, data_o, exp_q.pop_front());
        @(posedge clk);
        #1;
        ce_i = 1'b0; we_i = 1'b0; sel_i = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data,
                      input string name);
        access(1'b1, 1'b1, addr, sel, data, 32'h0, name);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        access(1'b1, 1'b0, addr, 4'hF, 32'h0, exp, name);
    endtask

    initial begin
        rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;

        tbl.push_back('{1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h1122_3344, 32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'h0000_0040, 4'h9, 32'hAA00_00BB, 32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'hAA22_33BB, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h0000_0040, 4'hF, 32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'h0000_0FFC, 4'hF, 32'h5A5A_A5A5, 32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         32'h5A5A_A5A5, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'h0000_0040, 4'h0, 32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h0000_0043, 4'hF, 32'h0,         32'hAA22_33BB, 1'b0});
        tbl.push_back('{1'b1, 1'b1, MB + 32'hC,    4'h1, 32'hFFFF_A5C3, 32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b0, MB + 32'hC,    4'hF, 32'h0,         32'h0000_00C3, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h2000_0000, 4'hF, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b1, 1'b0, MB + 32'h8,    4'hF, 32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b0, MB + 32'h4,    4'hF, 32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b1, 1'b0, MB + 32'h10,   4'hF, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'h0,         32'h0,         1'b0});

        // reset state
        @(posedge clk); #1;
        check32("reset timer_int", {31'd0, timer_int_o}, 32'd0);
        check32("reset gpio", {16'd0, gpio_o}, 32'd0);
        check32("reset bad_addr", {31'd0, bad_addr_o}, 32'd0);
        rst = 1'b1;
        rd(MB, 32'd0, "reset COUNT");
        rd(MB, 32'd1, "COUNT increments");

        foreach (tbl[i]) begin
            access(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].data,
                   tbl[i].exp_data, $sformatf("vec%0d data", i));
            check32($sformatf("vec%0d bad_addr", i), {31'd0, bad_addr_o}, {31'd0, tbl[i].exp_bad});
        end
        check32("gpio_o lane write", {16'd0, gpio_o}, 32'h0000_00C3);

        // timer match
        wr(MB + 32'h4, 4'hF, 32'd5, "wr COMPARE 5");
        wr(MB, 4'hF, 32'd0, "wr COUNT 0");
        for (int i = 0; i <= 5; i++) begin
            rd(MB, 32'(i), $sformatf("timer COUNT %0d", i));
            check32($sformatf("timer_int after COUNT %0d", i), {31'd0, timer_int_o}, {31'd0, i == 5});
        end
        wr(MB + 32'h8, 4'h1, 32'd1, "wr STATUS clear");
        check32("timer_int cleared", {31'd0, timer_int_o}, 32'd0);
        wr(MB, 4'hF, 32'd4, "wr COUNT 4");
        rd(MB, 32'd4, "COUNT 4");
        wr(MB + 32'h8, 4'h1, 32'd1, "clear on match");
        check32("set beats clear", {31'd0, timer_int_o}, 32'd1);
        rd(MB + 32'h8, 32'd1, "STATUS pending");
        wr(MB + 32'h8, 4'hE, 32'hFFFF_FFFF, "STATUS clear lane0 off");
        check32("clear needs sel0", {31'd0, timer_int_o}, 32'd1);
        wr(MB + 32'h8, 4'h1, 32'd1, "STATUS clear again");
        check32("timer_int cleared again", {31'd0, timer_int_o}, 32'd0);

        // wrap with matching disabled
        wr(MB + 32'h4, 4'hF, 32'd0, "wr COMPARE 0");
        wr(MB, 4'hF, 32'hFFFF_FFFE, "wr COUNT FFFFFFFE");
        rd(MB, 32'hFFFF_FFFE, "wrap FFFFFFFE");
        rd(MB, 32'hFFFF_FFFF, "wrap FFFFFFFF");
        rd(MB, 32'h0000_0000, "wrap 0");
        rd(MB, 32'h0000_0001, "wrap 1");
        check32("compare0 no int", {31'd0, timer_int_o}, 32'd0);

        // synchronous reset with live state
        wr(MB + 32'h4, 4'hF, 32'd200, "wr COMPARE 200");
        wr(MB, 4'hF, 32'd198, "wr COUNT 198");
        rd(MB, 32'd198, "COUNT 198");
        rd(MB, 32'd199, "COUNT 199");
        rd(MB, 32'd200, "COUNT 200");
        check32("pending before reset", {31'd0, timer_int_o}, 32'd1);
        wr(MB + 32'hC, 4'hF, 32'h0000_BEEF, "wr GPIO BEEF");
        wr(MB, 4'hF, 32'd123, "wr COUNT 123");
        rd(MB, 32'd123, "COUNT 123");
        check32("gpio BEEF", {16'd0, gpio_o}, 32'h0000_BEEF);
        rst = 1'b0;
        wr(32'h0000_0040, 4'hF, 32'h0000_0000, "write during reset");
        rst = 1'b1;
        check32("post-reset timer_int", {31'd0, timer_int_o}, 32'd0);
        check32("post-reset gpio", {16'd0, gpio_o}, 32'd0);
        check32("post-reset bad_addr", {31'd0, bad_addr_o}, 32'd0);
        rd(MB, 32'd0, "post-reset COUNT 0");
        rd(MB, 32'd1, "post-reset COUNT 1");
        rd(MB + 32'h4, 32'd0, "post-reset COMPARE");
        rd(MB + 32'h8, 32'd0, "post-reset STATUS");
        rd(MB + 32'hC, 32'd0, "post-reset GPIO");
        rd(32'h0000_0040, 32'hAA22_33BB, "RAM kept through reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
